// File: rtl/bcd_subtractor_serial_if.sv
// Request/result bundle for the digit-serial packed-BCD subtractor.
// The master drives the operands and start; the slave returns status and result.
interface bcd_subtractor_serial_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   d;
  logic                  borrow;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, d, borrow, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, borrow, invalid
  );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: d = a - b, least-significant digit first,
// one digit per clock, with borrow out in ten's-complement form.
module bcd_subtractor_serial #(
  parameter int unsigned DIGITS = 2
) (
  input logic                   clk,
  input logic                   reset,
  bcd_subtractor_serial_if.slave bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   a_q, b_q, res_q, d_q;
  logic           bin_q, busy_q, done_q, borrow_q, invalid_q;
  logic [CW-1:0]  cnt_q;

  logic [4:0]     diff;
  logic           bout;
  logic [3:0]     digit;
  logic [W+3:0]   shifted;
  logic [W-1:0]   res_next;
  logic           last_digit;
  logic           bad_in;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // The working operands shift right so the current digit is always at [3:0].
  always_comb begin
    diff       = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, bin_q};
    bout       = diff[4];
    digit      = bout ? (diff[3:0] + 4'd10) : diff[3:0];
    shifted    = {digit, res_q};
    res_next   = shifted[W+3:4];
    last_digit = (cnt_q == CW'(DIGITS - 1));
    bad_in     = has_bad_digit(bus.a) | has_bad_digit(bus.b);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      d_q       <= '0;
      bin_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            if (bad_in) begin
              d_q       <= '0;
              borrow_q  <= 1'b0;
              invalid_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              bin_q   <= 1'b0;
              cnt_q   <= '0;
              res_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          res_q <= res_next;
          bin_q <= bout;
          cnt_q <= cnt_q + 1'b1;
          if (last_digit) begin
            d_q       <= res_next;
            borrow_q  <= bout;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.d       = d_q;
  assign bus.borrow  = borrow_q;
  assign bus.invalid = invalid_q;
endmodule
